// File: rtl/branch_resolve_unit.sv
// Branch-resolution stage: evaluates the RISC-V conditional-branch funct3
// conditions, computes target / next PC, flags mispredictions and illegal
// funct3 codes, and keeps saturating branch / mispredict counters.
// One-deep result register with a valid/ready handshake and a flush input.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_mispredict,
    output logic             out_illegal,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispredicts
);

    localparam logic [XLEN-1:0]  PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = val;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    logic             out_valid_r;
    logic             out_taken_r;
    logic [XLEN-1:0]  out_next_pc_r;
    logic             out_mispredict_r;
    logic             out_illegal_r;
    logic [CNT_W-1:0] cnt_branches_r;
    logic [CNT_W-1:0] cnt_mispredicts_r;

    logic             cond_s;
    logic             illegal_s;
    logic             taken_s;
    logic             mispredict_s;
    logic [XLEN-1:0]  target_s;
    logic [XLEN-1:0]  fall_s;
    logic [XLEN-1:0]  next_pc_s;
    logic             accept_s;
    logic             consume_s;

    // Ready is deliberately not gated by flush; flush only blocks acceptance.
    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready && !flush;
    assign consume_s = out_valid_r && out_ready && !flush;

    // Branch condition decode; reserved funct3 codes resolve not-taken.
    always_comb begin
        cond_s    = 1'b0;
        illegal_s = 1'b0;
        case (in_op)
            3'b000:  cond_s = (in_rs1 == in_rs2);
            3'b001:  cond_s = (in_rs1 != in_rs2);
            3'b100:  cond_s = ($signed(in_rs1) <  $signed(in_rs2));
            3'b101:  cond_s = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110:  cond_s = (in_rs1 <  in_rs2);
            3'b111:  cond_s = (in_rs1 >= in_rs2);
            default: illegal_s = 1'b1;   // 010 and 011 are reserved
        endcase
    end

    // Target / fall-through arithmetic wraps modulo 2^XLEN.
    always_comb begin
        target_s     = in_pc + in_imm;
        fall_s       = in_pc + PC_STEP;
        taken_s      = cond_s && !illegal_s;
        mispredict_s = !illegal_s && (taken_s != in_pred_taken);
        if (taken_s) begin
            next_pc_s = target_s;
        end else begin
            next_pc_s = fall_s;
        end
    end

    // Output-valid state: flush beats accept, accept beats drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Result fields load only on accept so they stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_taken_r      <= 1'b0;
            out_next_pc_r    <= {XLEN{1'b0}};
            out_mispredict_r <= 1'b0;
            out_illegal_r    <= 1'b0;
        end else if (accept_s) begin
            out_taken_r      <= taken_s;
            out_next_pc_r    <= next_pc_s;
            out_mispredict_r <= mispredict_s;
            out_illegal_r    <= illegal_s;
        end
    end

    // Performance counters count consumed results; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branches_r    <= {CNT_W{1'b0}};
            cnt_mispredicts_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_branches_r    <= {CNT_W{1'b0}};
            cnt_mispredicts_r <= {CNT_W{1'b0}};
        end else if (consume_s) begin
            if (!out_illegal_r) begin
                cnt_branches_r <= sat_inc(cnt_branches_r);
            end
            if (out_mispredict_r) begin
                cnt_mispredicts_r <= sat_inc(cnt_mispredicts_r);
            end
        end
    end

    assign out_valid       = out_valid_r;
    assign out_taken       = out_taken_r;
    assign out_next_pc     = out_next_pc_r;
    assign out_mispredict  = out_mispredict_r;
    assign out_illegal     = out_illegal_r;
    assign cnt_branches    = cnt_branches_r;
    assign cnt_mispredicts = cnt_mispredicts_r;

endmodule
